// File: rtl/nf_cdc_arb.sv
// nf_cdc_arb
// Round-robin arbiter and transaction sequencer in front of one port of the
// two-register CDC mailbox. Serialises local writes, strobes the mailbox,
// follows its wait flag to completion, aborts hung transfers, and tracks a
// shadow of the mailbox contents so updates from the far domain are flagged.
module nf_cdc_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    output logic                    busy,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rd_valid,
    output logic                    cdc_we,
    output logic [WIDTH-1:0]        cdc_wdata,
    input  logic                    cdc_wait,
    input  logic [WIDTH-1:0]        cdc_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic [WIDTH-1:0] pick_data;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic             seen_hi;
    logic             remote_chg;

    // (base + off) mod NREQ; both operands are below NREQ so one fold suffices
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IW'(s);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    // The WAIT counter holds at its ceiling instead of wrapping
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Round-robin pick: first requester at or after ptr; scanning from the far
    // end lets the nearest offset overwrite the others
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(ptr, i);
            end
        end
    end

    assign pick_data = wdata[int'(pick_idx)*WIDTH +: WIDTH];

    // A quiet mailbox holding something other than our shadow was written remotely.
    // Equal-value remote writes are indistinguishable and go unreported.
    assign remote_chg = !cdc_wait && (cdc_rdata != shadow);

    assign rdata = shadow;

    // Transaction sequencer with registered grant, strobe and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            ptr       <= '0;
            cnt       <= '0;
            seen_hi   <= 1'b0;
            shadow    <= '0;
            cdc_wdata <= '0;
            cdc_we    <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            done     <= '0;
            err      <= '0;
            rd_valid <= 1'b0;
            cdc_we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Remote capture wins; a pending grant simply waits a cycle
                    if (remote_chg) begin
                        shadow   <= cdc_rdata;
                        rd_valid <= 1'b1;
                    end else if (!cdc_wait && pick_vld) begin
                        idx       <= pick_idx;
                        cdc_wdata <= pick_data;
                        gnt       <= onehot(pick_idx);
                        cdc_we    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt     <= '0;
                    seen_hi <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion needs the flag to have risen and then fallen
                    if (cdc_wait) begin
                        seen_hi <= 1'b1;
                    end
                    if (seen_hi && !cdc_wait) begin
                        done  <= gnt;
                        state <= S_DONE;
                    end else if (cnt == CNT_MAX) begin
                        err   <= gnt;
                        state <= S_ERR;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_DONE: begin
                    shadow <= cdc_wdata;
                    ptr    <= wrap_add(idx, 1);
                    gnt    <= '0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    ptr   <= wrap_add(idx, 1);
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
